// File: rtl/frequency_meter.sv
// frequency_meter: counts rising edges of an asynchronous square wave over a
// fixed gate window of system-clock cycles and publishes the count with a
// one-cycle valid strobe. Back-to-back windows run without a dead cycle.
module frequency_meter #(
  parameter int CLK_HZ  = 50000000,
  parameter int GATE_MS = 1000,
  parameter int CNT_W   = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int GATE_CYCLES = (CLK_HZ / 1000) * GATE_MS;
  localparam int GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  // A window shorter than two cycles cannot separate counting from publishing.
  generate
    if (GATE_CYCLES < 2) begin : g_gate_check
      $error("frequency_meter: GATE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // Saturating increment; returns {overflowed, result}. The result sticks at
  // all-ones once the counter is full.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic             b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{CNT_W{1'b0}}, b};
    if (sum[CNT_W]) begin
      return {1'b1, {CNT_W{1'b1}}};
    end
    return sum;
  endfunction

  state_t            state_q,    state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q,      sat_d;
  logic [CNT_W-1:0]  freq_q,     freq_d;
  logic              ovf_q,      ovf_d;
  logic              valid_q,    valid_d;
  logic              sig_p0_q,   sig_p0_d;
  logic              sig_p1_q,   sig_p1_d;
  logic              sig_p2_q,   sig_p2_d;

  logic              edge_now;
  logic              inc_ovf;
  logic [CNT_W-1:0]  inc_val;

  // p0/p1: two-flop synchroniser; p2: previous synchronised level for edge detect.
  always_comb begin
    sig_p0_d = sig_in;
    sig_p1_d = sig_p0_q;
    sig_p2_d = sig_p1_q;
  end

  // Input synchroniser and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_p0_q <= 1'b0;
      sig_p1_q <= 1'b0;
      sig_p2_q <= 1'b0;
    end else begin
      sig_p0_q <= sig_p0_d;
      sig_p1_q <= sig_p1_d;
      sig_p2_q <= sig_p2_d;
    end
  end

  assign edge_now           = sig_p1_q & ~sig_p2_q;
  assign {inc_ovf, inc_val} = sat_add(edge_cnt_q, edge_now);

  // Next-state logic: gate counting, window close/publish, abort on en low.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (en) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          // The edge seen on the closing cycle still belongs to this window,
          // so a window that ends with en low still publishes normally.
          freq_d     = inc_val;
          ovf_d      = sat_q | inc_ovf;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          if (!en) begin
            state_d = IDLE;
          end
        end else if (!en) begin
          // Partial window is discarded; published results are untouched.
          state_d    = IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
          edge_cnt_d = inc_val;
          sat_d      = sat_q | inc_ovf;
        end
      end
      default: begin
        state_d    = IDLE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
      end
    endcase
  end

  // State, counters and published result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign freq  = freq_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;
  assign busy  = (state_q == GATE);

endmodule
